// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one instruction per request/grant/response
// handshake and hands it to the control logic until that logic accepts it.
//
// state | meaning
// BOOT  | first cycle out of reset, no request yet
// REQ   | request driven at PC, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction valid, waiting for accept
// FAULT | misaligned next PC seen, halted until reset
module instruction_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               imemReq_o,
  output logic [PC_W-1:0]    imemAddr_o,
  input  logic               imemGnt_i,
  input  logic               imemRvalid_i,
  input  logic [INSTR_W-1:0] imemRdata_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [PC_W-1:0]    programCounter_o,
  output logic               instrValid_o,
  input  logic               instrAccept_i,
  input  logic [PC_W-1:0]    nextProgramCounter_i,
  output logic               fault_o,
  output logic [CNT_W-1:0]   retiredCount_o
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FAULT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    fault_d = fault_q;
    count_d = count_q;
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        // rvalid without a grant cannot belong to this request, so it is ignored
        if (imemGnt_i) begin
          req_d = 1'b0;
          if (imemRvalid_i) begin
            instr_d = imemRdata_i;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imemRvalid_i) begin
          instr_d = imemRdata_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instrAccept_i) begin
          count_d = count_q + CNT_W'(1);
          valid_d = 1'b0;
          if (nextProgramCounter_i[1:0] == 2'b00) begin
            pc_d    = nextProgramCounter_i;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = FAULT;
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imemReq_o        = req_q;
  assign imemAddr_o       = pc_q;
  assign programCounter_o = pc_q;
  assign instruction_o    = instr_q;
  assign instrValid_o     = valid_q;
  assign fault_o          = fault_q;
  assign retiredCount_o   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a responder with random grant/response delays and
// a transaction-level model of PC, retired count, fault and fetched data.
module tb_instruction_fetch;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        imemReq_o;
  logic [31:0] imemAddr_o;
  logic        imemGnt_i = 1'b0;
  logic        imemRvalid_i = 1'b0;
  logic [31:0] imemRdata_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] programCounter_o;
  logic        instrValid_o;
  logic        instrAccept_i = 1'b0;
  logic [31:0] nextProgramCounter_i = '0;
  logic        fault_o;
  logic [31:0] retiredCount_o;

  instruction_fetch dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o),
    .imemGnt_i(imemGnt_i), .imemRvalid_i(imemRvalid_i), .imemRdata_i(imemRdata_i),
    .instruction_o(instruction_o), .programCounter_o(programCounter_o),
    .instrValid_o(instrValid_o), .instrAccept_i(instrAccept_i),
    .nextProgramCounter_i(nextProgramCounter_i),
    .fault_o(fault_o), .retiredCount_o(retiredCount_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  always @(posedge clk_i) cyc++;

  logic [31:0] exp_pc, exp_count, prev_instr;
  logic        exp_fault;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; exp_count = 32'h0; exp_fault = 1'b0; prev_instr = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"},   imemReq_o, 0);
    check_eq({tag, "_addr"},  imemAddr_o, 32'h0);
    check_eq({tag, "_valid"}, instrValid_o, 0);
    check_eq({tag, "_instr"}, instruction_o, 32'h0);
    check_eq({tag, "_pc"},    programCounter_o, 32'h0);
    check_eq({tag, "_fault"}, fault_o, 0);
    check_eq({tag, "_count"}, retiredCount_o, 32'h0);
  endtask

  // One fetch: wait_cyc cycles before the request is due, grant after d_g cycles,
  // data lat cycles after grant (0 = same cycle), accept after acc_dly cycles.
  task automatic fetch_txn(input int wait_cyc, input int d_g, input int lat,
                           input int acc_dly, input logic [31:0] npc);
    for (int i = 0; i < wait_cyc; i++) begin
      check_eq("pre_req_low", imemReq_o, 0);
      step();
    end
    check_eq("req_high", imemReq_o, 1);
    check_eq("req_addr", imemAddr_o, exp_pc);
    check_eq("req_valid_low", instrValid_o, 0);
    check_eq("req_instr_kept", instruction_o, prev_instr);
    for (int i = 0; i < d_g; i++) begin
      imemGnt_i = 1'b0;
      imemRvalid_i = 1'($urandom_range(0, 1));
      imemRdata_i = $urandom;
      step();
      check_eq("stall_req", imemReq_o, 1);
      check_eq("stall_addr", imemAddr_o, exp_pc);
      check_eq("stall_valid", instrValid_o, 0);
      check_eq("stall_instr", instruction_o, prev_instr);
    end
    imemGnt_i = 1'b1;
    imemRvalid_i = (lat == 0);
    imemRdata_i = (lat == 0) ? mem_word(exp_pc) : $urandom;
    step();
    imemGnt_i = 1'b0;
    imemRvalid_i = 1'b0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        check_eq("wait_req", imemReq_o, 0);
        check_eq("wait_valid", instrValid_o, 0);
        check_eq("wait_instr", instruction_o, prev_instr);
        step();
      end
      check_eq("wait_req", imemReq_o, 0);
      check_eq("wait_valid", instrValid_o, 0);
      imemRvalid_i = 1'b1;
      imemRdata_i = mem_word(exp_pc);
      step();
      imemRvalid_i = 1'b0;
    end
    check_eq("hold_valid", instrValid_o, 1);
    check_eq("hold_instr", instruction_o, mem_word(exp_pc));
    check_eq("hold_pc", programCounter_o, exp_pc);
    check_eq("hold_count", retiredCount_o, exp_count);
    check_eq("hold_req", imemReq_o, 0);
    prev_instr = mem_word(exp_pc);
    for (int i = 0; i < acc_dly; i++) begin
      imemRvalid_i = 1'($urandom_range(0, 1));
      imemRdata_i = $urandom;
      step();
      check_eq("hold_stable_valid", instrValid_o, 1);
      check_eq("hold_stable_instr", instruction_o, prev_instr);
      check_eq("hold_stable_pc", programCounter_o, exp_pc);
    end
    imemRvalid_i = 1'b0;
    instrAccept_i = 1'b1;
    nextProgramCounter_i = npc;
    step();
    instrAccept_i = 1'b0;
    nextProgramCounter_i = $urandom;
    exp_count = exp_count + 32'd1;
    if (npc[1:0] == 2'b00) exp_pc = npc;
    else exp_fault = 1'b1;
    check_eq("acc_valid", instrValid_o, 0);
    check_eq("acc_count", retiredCount_o, exp_count);
    check_eq("acc_fault", fault_o, exp_fault);
    check_eq("acc_pc", programCounter_o, exp_pc);
    check_eq("acc_instr", instruction_o, prev_instr);
    check_eq("acc_req", imemReq_o, !exp_fault);
  endtask

  function automatic logic [31:0] rand_aligned();
    logic [31:0] v;
    v = $urandom;
    v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    longint c0;
    model_reset();
    repeat (3) step();
    check_reset_vals("rst_init");
    reset_i = 1'b0;
    check_eq("boot_req", imemReq_o, 0);

    // first fetch at 0, then accept to 4
    fetch_txn(1, 0, 1, 0, 32'h4);
    // grant withheld 5 cycles
    fetch_txn(0, 5, 1, 1, rand_aligned());
    for (int n = 0; n < 30; n++)
      fetch_txn(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), rand_aligned());
    fetch_txn(0, 1, 0, 0, 32'hFFFF_FFFC);
    fetch_txn(0, 0, 2, 1, 32'h0);

    // zero-latency back-to-back
    reset_i = 1'b1;
    model_reset();
    step();
    check_reset_vals("rst_mid");
    reset_i = 1'b0;
    step();
    c0 = cyc;
    for (int n = 0; n < 10; n++)
      fetch_txn(0, 0, 0, 0, exp_pc + 32'd4);
    check_eq("b2b_cycles", 64'(cyc - c0), 64'd20);
    check_eq("b2b_count", retiredCount_o, 32'd10);

    // misaligned next PC
    fetch_txn(0, 1, 2, 0, 32'h6);
    for (int i = 0; i < 8; i++) begin
      imemGnt_i = 1'($urandom_range(0, 1));
      imemRvalid_i = 1'($urandom_range(0, 1));
      imemRdata_i = $urandom;
      instrAccept_i = 1'($urandom_range(0, 1));
      nextProgramCounter_i = rand_aligned();
      step();
      check_eq("fault_req", imemReq_o, 0);
      check_eq("fault_valid", instrValid_o, 0);
      check_eq("fault_flag", fault_o, 1);
      check_eq("fault_count", retiredCount_o, exp_count);
      check_eq("fault_pc", programCounter_o, exp_pc);
    end
    imemGnt_i = 1'b0; imemRvalid_i = 1'b0; instrAccept_i = 1'b0;
    reset_i = 1'b1;
    model_reset();
    step();
    check_reset_vals("rst_fault");

    // reset while in WAIT for PC 0x40
    reset_i = 1'b0;
    step();
    fetch_txn(0, 0, 0, 0, 32'h40);
    imemGnt_i = 1'b1;
    step();
    imemGnt_i = 1'b0;
    check_eq("wait40_req", imemReq_o, 0);
    check_eq("wait40_addr", imemAddr_o, 32'h40);
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    check_reset_vals("rst_async");
    step();
    reset_i = 1'b0;
    step();
    check_eq("post_rst_req", imemReq_o, 1);
    check_eq("post_rst_addr", imemAddr_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
